// File: rtl/regfile_pkg.sv
// Shared constants and the byte-merge helper for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned REG_ZERO     = 0;
  localparam int unsigned REG_V0       = 2;

  // One byte lane of a byte-enabled write: take the new byte only when enabled.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the register file: read ports, two write ports,
// busy marking and the debug/scoreboard outputs.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
);

  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic [1:0]                 wr_en;
  logic [2*ADDR_W-1:0]        wr_addr;
  logic [2*DATA_W-1:0]        wr_data;
  logic [2*(DATA_W/8)-1:0]    wr_be;
  logic [1:0]                 wr_clr;
  logic                       mark_en;
  logic [ADDR_W-1:0]          mark_addr;
  logic [NUM_REGS-1:0]        busy_vec;
  logic [DATA_W-1:0]          regv0;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_be, wr_clr, mark_en, mark_addr,
    input  rd_data, rd_busy, busy_vec, regv0
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_be, wr_clr, mark_en, mark_addr,
    output rd_data, rd_busy, busy_vec, regv0
  );

endinterface

// File: rtl/regfile_bypass_mux.sv
// Per read port: folds this cycle's pending writes (and busy clears) into the
// stored value when bypass is enabled.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        stored_data,
  input  logic                     stored_busy,
  input  logic [1:0]               wr_en,
  input  logic [2*ADDR_W-1:0]      wr_addr,
  input  logic [2*DATA_W-1:0]      wr_data,
  input  logic [2*(DATA_W/8)-1:0]  wr_be,
  input  logic [1:0]               wr_clr,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_busy
);

  localparam int unsigned NB = DATA_W / 8;

  logic [1:0] hit;
  logic       clr_hit;

  // Port 0 merged before port 1 so the younger write wins shared bytes.
  always_comb begin
    rd_data = stored_data;
    rd_busy = stored_busy;
    hit     = '0;
    clr_hit = 1'b0;
    if (BYPASS != 0) begin
      for (int p = 0; p < 2; p++) begin
        hit[p] = wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == rd_addr) &&
                 (rd_addr != ADDR_W'(REG_ZERO));
        if (hit[p]) begin
          for (int b = 0; b < NB; b++) begin
            rd_data[b*8 +: 8] = byte_merge(rd_data[b*8 +: 8],
                                           wr_data[p*DATA_W + b*8 +: 8],
                                           wr_be[p*NB + b]);
          end
          if (wr_clr[p]) clr_hit = 1'b1;
        end
      end
      // A new producer marked on the same edge keeps the register busy.
      if (clr_hit && !(mark_en && (mark_addr == rd_addr))) rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port MIPS register file: NUM_RD combinational read ports, two
// prioritised byte-enabled write ports, busy scoreboard, async clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  localparam int unsigned ADDR_W = $clog2(NUM_REGS);
  localparam int unsigned NB     = DATA_W / 8;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Writes and marks are suppressed while reset is held, which also keeps the
  // bypass path from exposing write data during reset.
  logic [1:0] wen;
  logic       mark;
  assign wen  = bus.wr_en & {2{~reset}};
  assign mark = bus.mark_en & ~reset;

  logic [ADDR_W-1:0] waddr [2];
  logic [DATA_W-1:0] wdata [2];
  logic [NB-1:0]     wbe   [2];

  // Unpack the flat write-port buses.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      waddr[p] = bus.wr_addr[p*ADDR_W +: ADDR_W];
      wdata[p] = bus.wr_data[p*DATA_W +: DATA_W];
      wbe[p]   = bus.wr_be[p*NB +: NB];
    end
  end

  // Next register/busy state: port 1 applied after port 0, mark after clears.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int p = 0; p < 2; p++) begin
      if (wen[p] && (waddr[p] != ADDR_W'(REG_ZERO))) begin
        for (int b = 0; b < NB; b++) begin
          regs_d[waddr[p]][b*8 +: 8] = byte_merge(regs_d[waddr[p]][b*8 +: 8],
                                                  wdata[p][b*8 +: 8], wbe[p][b]);
        end
      end
      if (wen[p] && bus.wr_clr[p]) busy_d[waddr[p]] = 1'b0;
    end
    if (mark) busy_d[bus.mark_addr] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  // Storage and scoreboard with asynchronous clear (flops, not RAM).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign bus.busy_vec = busy_q;
  assign bus.regv0    = regs_q[REG_V0];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdata;
    logic              rbusy;

    assign ra = bus.rd_addr[i*ADDR_W +: ADDR_W];

    regfile_bypass_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_mux (
      .rd_addr     (ra),
      .stored_data (regs_q[ra]),
      .stored_busy (busy_q[ra]),
      .wr_en       (wen),
      .wr_addr     (bus.wr_addr),
      .wr_data     (bus.wr_data),
      .wr_be       (bus.wr_be),
      .wr_clr      (bus.wr_clr),
      .mark_en     (mark),
      .mark_addr   (bus.mark_addr),
      .rd_data     (rdata),
      .rd_busy     (rbusy)
    );

    assign bus.rd_data[i*DATA_W +: DATA_W] = rdata;
    assign bus.rd_busy[i]                  = rbusy;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS CPU datapath; next-generation replacement for the single-write, two-read file. Adds configurable read-port count, two prioritised write ports with byte enables, optional same-cycle write-to-read bypass, a per-register busy scoreboard for in-flight producers, and asynchronous clear. Sits between decode (reads, busy marking) and writeback (writes, busy clearing).

## Interface
- DATA_W, 32, register width in bits; multiple of 8
- NUM_REGS, 32, register count; power of two, >= 2
- NUM_RD, 2, number of read ports, 1..4
- BYPASS, 1, 1 = same-cycle write visible on reads and busy; 0 = read old value
- ADDR_W, $clog2(NUM_REGS), derived; not to be overridden
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all registers and busy bits
- rd_addr  input  NUM_RD*ADDR_W  read selectors, port i at [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  output  NUM_RD  busy flag of the selected register per read port
- wr_en  input  2  write enable per write port
- wr_addr  input  2*ADDR_W  write selectors
- wr_data  input  2*DATA_W  write data
- wr_be  input  2*(DATA_W/8)  byte enables per write port
- wr_clr  input  2  clear busy of the written register when that port writes
- mark_en  input  1  set busy of mark_addr
- mark_addr  input  ADDR_W  register gaining an in-flight producer
- busy_vec  output  NUM_REGS  full scoreboard, bit r = register r busy
- regv0  output  DATA_W  debug: stored (non-bypassed) value of register 2

## Operation
- Register 0: reads 0, writes ignored, never busy (mark/clear on 0 ignored).
- Write: on rising edge, for each port with wr_en=1 and addr!=0, bytes with wr_be=1 take wr_data; other bytes keep old value.
- Same-address collision: merged per byte; where both ports enable a byte, port 1 wins (port 1 is younger in program order).
- wr_be all-zero with wr_en=1: data unchanged; wr_clr still honoured.
- Busy: mark_en sets busy[mark_addr]; wr_en&wr_clr on port p clears busy[wr_addr_p]. Mark and clear same register same edge -> stays busy (new producer wins).
- Read (combinational): rd_data = stored value; if BYPASS=1, merged with this cycle's pending writes using the same byte/priority rules.
- rd_busy: stored busy bit; if BYPASS=1 and a clearing write targets the register this cycle and no mark to same register, rd_busy=0.
- Duplicate read addresses across ports return identical data/busy.
- busy_vec and regv0 always show stored state, never bypassed.

## Timing
- Reset asserted: all registers 0, busy_vec=0 immediately (asynchronous, mid-cycle); writes and marks ignored while asserted; rd_data=0 and rd_busy=0 on all ports regardless of write inputs.
- Reset release: first edge with reset low performs normal updates.
- Write latency: stored value and regv0 update 1 cycle after edge; bypassed read sees value 0 cycles (same cycle as wr_en).
- Busy latency: mark visible on busy_vec/rd_busy the cycle after mark_en.
- No handshake; every input sampled every edge; no stalls.

## Structure
- Package regfile_pkg: REG_ZERO (0), REG_V0 (2) constants, default DATA_W/NUM_REGS, function merging data by byte enable.
- One sub-module: regfile_bypass_mux (per read port: stored value + two write ports -> bypassed data/busy), instantiated NUM_RD times via generate.
- Storage and scoreboard in top level; storage must not infer reset-less RAM when reset is required.

## Test plan
- Reset mid-run: write 0xDEADBEEF to r5, mark r7, assert reset between edges -> r5 reads 0, busy_vec=0 before next edge.
- Zero register: write 0xFFFFFFFF to r0 on both ports, mark r0 -> rd_data=0, busy_vec[0]=0.
- Byte enables and collision: r3=0x11223344; port0 writes 0xAAAAAAAA be=0b0011, port1 writes 0xBBBBBBBB be=0b0110 same edge -> r3=0x11BBBBAA.
- Bypass: BYPASS=1, wr port0 r4=0x12345678, rd_addr port1=r4 same cycle -> rd_data=0x12345678; BYPASS=0 -> old value, new value next cycle.
- Scoreboard: mark r9 -> busy next cycle; wr r9 with wr_clr and mark r9 same edge -> still busy; clear alone -> busy_vec[9]=0, rd_busy=0 same cycle when BYPASS=1.
- Debug: write 0x00000042 to r2 -> regv0=0x42 one cycle later, not in the write cycle.
